// File: rtl/store_queue.sv
// store_queue: in-order store buffer between the core store port and memory.
// Merges a store into the newest entry when it targets the same address.
module store_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_we,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [DATA_W-1:0]          st_data,
    output logic                       st_full,
    output logic                       mem_valid,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    input  logic                       mem_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     tail_ptr;
    logic [CW-1:0]     count_q;
    logic              overflow_q;

    logic pop;
    logic merge;
    logic push;
    logic drop;

    assign tail_ptr = wr_ptr - PW'(1);

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign st_full   = (count_q == FULL_CNT);
    assign mem_valid = (count_q != '0);

    // Head is gated so a drained queue shows zeros rather than stale data.
    assign mem_addr = mem_valid ? addr_q[rd_ptr] : '0;
    assign mem_data = mem_valid ? data_q[rd_ptr] : '0;

    assign pop = mem_valid & mem_ready;

    // A lone entry leaving this cycle cannot absorb a new store.
    assign merge = st_we & mem_valid
                 & (st_addr == addr_q[tail_ptr])
                 & ~(pop & (count_q == CW'(1)));

    assign push = st_we & ~merge & (~st_full | pop);
    assign drop = st_we & ~merge & ~push;

    // Entry storage: write new tail on push, overwrite newest data on merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= st_addr;
                data_q[wr_ptr] <= st_data;
            end
            if (merge) begin
                data_q[tail_ptr] <= st_data;
            end
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule
